cav_lock_seq: RTL and testbench
===============================

CAV_LOCK_SEQ -- requirements
Module: cav_lock_seq

Interface
REQ-001 SHALL have parameter FILTER_IO_SIZE, default 25, word length of all signed signal ports.
REQ-002 SHALL have parameter SETTLE_CYC, default 1000, cycles transmission must stay above thr_lost before LOCKED.
REQ-003 SHALL have parameter LOST_CYC, default 100, consecutive low-transmission cycles that declare lock loss.
REQ-004 SHALL have port clk, in, 1, the single system clock; all logic rising-edge.
REQ-005 SHALL have port rst_n, in, 1, asynchronous active-low reset.
REQ-006 SHALL have port en, in, 1, sequencer enable.
REQ-007 SHALL have port trans, in, FILTER_IO_SIZE signed, cavity transmission sample.
REQ-008 SHALL have ports thr_lock and thr_lost, in, FILTER_IO_SIZE signed, engage and loss thresholds.
REQ-009 SHALL have ports sweep_LL and sweep_UL, in, FILTER_IO_SIZE signed, sweep limits.
REQ-010 SHALL have ports sweep_step, in, 16 unsigned, ramp increment, and sweep_div, in, 16 unsigned, cycles per ramp step minus one.
REQ-011 SHALL have ports LL and UL, in, FILTER_IO_SIZE signed, servo output limits used for rail detection.
REQ-012 SHALL have port pid_out, in, FILTER_IO_SIZE signed, servo output fed back for rail detection.
REQ-013 SHALL have ports pid_on and pid_hld, out, 1, servo enable and integrator hold.
REQ-014 SHALL have port sweep_out, out, FILTER_IO_SIZE signed, sweep/offset value summed with servo output downstream.
REQ-015 SHALL have ports locked, out, 1; state, out, 2; relock_cnt, out, 8 unsigned.

Function
REQ-016 SHALL implement states IDLE=0, SWEEP=1, ENGAGE=2, LOCKED=3, reported on state, registered.
REQ-017 IDLE: pid_on=0, sweep_out held; en=1 -> SWEEP next cycle.
REQ-018 SWEEP: triangle ramp; every (sweep_div+1) cycles sweep_out moves sweep_step toward current direction, computed in FILTER_IO_SIZE+1 bits, clamped at sweep_UL/sweep_LL, direction reverses on reaching a limit.
REQ-019 If sweep_LL >= sweep_UL, sweep_out SHALL equal sweep_LL and not move.
REQ-020 SWEEP with trans >= thr_lock -> ENGAGE next cycle; sweep_out frozen; pid_on=1 from the ENGAGE cycle on.
REQ-021 ENGAGE: counter counts cycles with trans >= thr_lost; any trans < thr_lost -> SWEEP with pid_on=0 next cycle; count reaching SETTLE_CYC -> LOCKED.
REQ-022 LOCKED: locked=1, pid_on=1; trans < thr_lost asserts pid_hld same-cycle-registered (next cycle) and increments loss counter; trans >= thr_lost clears counter and pid_hld.
REQ-023 LOCKED: loss counter reaching LOST_CYC, or pid_out >= UL or pid_out <= LL for 2 consecutive cycles -> SWEEP, pid_on=0, pid_hld=0, locked=0, relock_cnt+1 saturating at 255.
REQ-024 en=0 in any state -> IDLE next cycle, pid_on=pid_hld=locked=0; relock_cnt retained.
REQ-025 Simultaneous loss and rail conditions SHALL count as one relock event.
REQ-026 SWEEP entry SHALL restart the ramp prescaler from zero, keep sweep_out and direction.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, sweep_out=0, direction=up, pid_on=pid_hld=locked=0, relock_cnt=0, all counters 0.
REQ-028 Reset deassertion mid-sweep SHALL restart from IDLE; first SWEEP step no earlier than sweep_div+1 cycles after entry.

Structure
REQ-029 State encoding and counter widths SHALL live in shared package cav_lock_pkg.
REQ-030 Ramp SHALL be sub-module tri_ramp (step, div, limits, run, value, direction).
REQ-031 All outputs SHALL be registered; no combinational path from inputs to outputs.

Verification
REQ-032 Reset then en=1, sweep_LL=-100, sweep_UL=100, step=10, div=0 -> sweep_out 0,10,...,100,90,...,-100, reversal at both limits.
REQ-033 In SWEEP set trans=500, thr_lock=400 -> ENGAGE next cycle, pid_on=1, sweep_out frozen; hold trans, SETTLE_CYC=8 -> locked=1 after 8 cycles.
REQ-034 LOCKED, trans drops below thr_lost for LOST_CYC-1 cycles then recovers -> pid_hld pulse, stays LOCKED, relock_cnt unchanged; LOST_CYC cycles -> SWEEP, relock_cnt=1.
REQ-035 LOCKED, pid_out=UL for 2 cycles -> SWEEP, pid_on=0; relock_cnt preset near 255 saturates at 255.
REQ-036 sweep_LL=50, sweep_UL=50 -> sweep_out constant 50; en=0 mid-ENGAGE -> IDLE, pid_on=0 next cycle; rst_n low mid-LOCKED -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cav_lock_pkg.sv
// Shared definitions for the cavity lock sequencer: state encoding, counter widths
// and a saturating increment for the relock event counter.
package cav_lock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        ENGAGE = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam int CNT_W    = 32;
    localparam int RELOCK_W = 8;
    localparam int DIV_W    = 16;

    localparam logic [RELOCK_W-1:0] RELOCK_MAX = '1;

    function automatic logic [RELOCK_W-1:0] sat_inc(input logic [RELOCK_W-1:0] v);
        return (v == RELOCK_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/tri_ramp.sv
// Triangle sweep generator: moves value by step every (div+1) enabled cycles,
// bouncing between lo and hi. The prescaler clears whenever run is low, so each
// new run restarts its timing while value and direction are kept.
module tri_ramp
    import cav_lock_pkg::*;
#(
    parameter int W = 25
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [DIV_W-1:0]    step,
    input  logic [DIV_W-1:0]    div,
    input  logic signed [W-1:0] lo,
    input  logic signed [W-1:0] hi,
    output logic signed [W-1:0] value,
    output logic                direction
);

    logic [DIV_W-1:0]  presc;
    logic signed [W:0] step_w;
    logic signed [W:0] lo_w;
    logic signed [W:0] hi_w;
    logic signed [W:0] val_w;
    logic signed [W:0] sum;
    logic signed [W:0] next_val;
    logic              next_dir;

    // One extra bit of headroom so the step cannot wrap before clamping.
    assign step_w = signed'({{(W+1-DIV_W){1'b0}}, step});
    assign lo_w   = {lo[W-1], lo};
    assign hi_w   = {hi[W-1], hi};
    assign val_w  = {value[W-1], value};

    // Candidate next ramp point with clamping and reversal at the limits.
    always_comb begin
        next_val = val_w;
        next_dir = direction;
        sum      = '0;
        if (direction) begin
            sum = val_w + step_w;
            if (sum >= hi_w) begin
                next_val = hi_w;
                next_dir = 1'b0;
            end else begin
                next_val = sum;
            end
        end else begin
            sum = val_w - step_w;
            if (sum <= lo_w) begin
                next_val = lo_w;
                next_dir = 1'b1;
            end else begin
                next_val = sum;
            end
        end
    end

    // Prescaler and ramp registers; a degenerate window pins value to lo.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            value     <= '0;
            direction <= 1'b1;
        end else if (!run) begin
            presc <= '0;
        end else if (lo >= hi) begin
            presc <= '0;
            value <= lo;
        end else if (presc == div) begin
            presc     <= '0;
            value     <= next_val[W-1:0];
            direction <= next_dir;
        end else begin
            presc <= presc + 1'b1;
        end
    end

endmodule

// File: rtl/cav_lock_seq.sv
// Cavity lock acquisition sequencer: sweeps the actuator until transmission
// appears, engages the servo, declares lock after a settle period and falls back
// to sweeping on sustained transmission loss or a railed servo output.
module cav_lock_seq
    import cav_lock_pkg::*;
#(
    parameter int FILTER_IO_SIZE = 25,
    parameter int SETTLE_CYC     = 1000,
    parameter int LOST_CYC       = 100
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic signed [FILTER_IO_SIZE-1:0] trans,
    input  logic signed [FILTER_IO_SIZE-1:0] thr_lock,
    input  logic signed [FILTER_IO_SIZE-1:0] thr_lost,
    input  logic signed [FILTER_IO_SIZE-1:0] sweep_LL,
    input  logic signed [FILTER_IO_SIZE-1:0] sweep_UL,
    input  logic [DIV_W-1:0]                 sweep_step,
    input  logic [DIV_W-1:0]                 sweep_div,
    input  logic signed [FILTER_IO_SIZE-1:0] LL,
    input  logic signed [FILTER_IO_SIZE-1:0] UL,
    input  logic signed [FILTER_IO_SIZE-1:0] pid_out,
    output logic                             pid_on,
    output logic                             pid_hld,
    output logic signed [FILTER_IO_SIZE-1:0] sweep_out,
    output logic                             locked,
    output logic [1:0]                       state,
    output logic [RELOCK_W-1:0]              relock_cnt
);

    state_t            cur;
    state_t            nxt;
    logic [CNT_W-1:0]  settle_cnt;
    logic [CNT_W-1:0]  loss_cnt;
    logic              rail_seen;
    logic              low;
    logic              rail;
    logic              loss_trip;
    logic              rail_trip;
    logic              relock_evt;
    logic              ramp_dir;

    assign low        = (trans < thr_lost);
    assign rail       = (pid_out >= UL) || (pid_out <= LL);
    assign loss_trip  = low && (loss_cnt == CNT_W'(LOST_CYC - 1));
    assign rail_trip  = rail && rail_seen;
    // Loss and rail tripping on the same cycle are one event.
    assign relock_evt = en && (cur == LOCKED) && (loss_trip || rail_trip);
    assign state      = cur;

    tri_ramp #(.W(FILTER_IO_SIZE)) u_ramp (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (cur == SWEEP),
        .step      (sweep_step),
        .div       (sweep_div),
        .lo        (sweep_LL),
        .hi        (sweep_UL),
        .value     (sweep_out),
        .direction (ramp_dir)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= IDLE;
        else        cur <= nxt;
    end

    // Next-state logic; disabling overrides every other transition.
    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:    if (en) nxt = SWEEP;
            SWEEP:   if (trans >= thr_lock) nxt = ENGAGE;
            ENGAGE:  if (low) nxt = SWEEP;
                     else if (settle_cnt == CNT_W'(SETTLE_CYC - 1)) nxt = LOCKED;
            LOCKED:  if (relock_evt) nxt = SWEEP;
            default: nxt = IDLE;
        endcase
        if (!en) nxt = IDLE;
    end

    // Counters and registered outputs, all derived from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            loss_cnt   <= '0;
            rail_seen  <= 1'b0;
            relock_cnt <= '0;
            pid_on     <= 1'b0;
            pid_hld    <= 1'b0;
            locked     <= 1'b0;
        end else begin
            settle_cnt <= (cur == ENGAGE && nxt == ENGAGE) ? settle_cnt + 1'b1 : '0;
            loss_cnt   <= (cur == LOCKED && nxt == LOCKED && low) ? loss_cnt + 1'b1 : '0;
            rail_seen  <= (cur == LOCKED) && (nxt == LOCKED) && rail;
            if (relock_evt) relock_cnt <= sat_inc(relock_cnt);
            pid_on     <= (nxt == ENGAGE) || (nxt == LOCKED);
            pid_hld    <= (cur == LOCKED) && (nxt == LOCKED) && low;
            locked     <= (nxt == LOCKED);
        end
    end

    logic unused_dir;
    assign unused_dir = ramp_dir;

endmodule

// File: tb/tb_cav_lock_seq.sv
// Directed bench for cav_lock_seq: ramp shape, engage/settle, loss and rail
// relock paths, relock saturation, disable, degenerate sweep window and reset.
module tb_cav_lock_seq;

    localparam int W = 25;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                en;
    logic signed [W-1:0] trans, thr_lock, thr_lost, sweep_LL, sweep_UL, LL, UL, pid_out;
    logic [15:0]         sweep_step, sweep_div;
    logic                pid_on, pid_hld, locked;
    logic signed [W-1:0] sweep_out;
    logic [1:0]          state;
    logic [7:0]          relock_cnt;

    int errors = 0;
    int checks = 0;
    int exp_v  = 0;
    bit exp_up = 1'b1;

    cav_lock_seq #(.FILTER_IO_SIZE(W), .SETTLE_CYC(8), .LOST_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .trans(trans),
        .thr_lock(thr_lock), .thr_lost(thr_lost),
        .sweep_LL(sweep_LL), .sweep_UL(sweep_UL),
        .sweep_step(sweep_step), .sweep_div(sweep_div),
        .LL(LL), .UL(UL), .pid_out(pid_out),
        .pid_on(pid_on), .pid_hld(pid_hld), .sweep_out(sweep_out),
        .locked(locked), .state(state), .relock_cnt(relock_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference triangle for limits -100..100, step 10.
    task automatic ramp_model();
        if (exp_up) begin
            exp_v += 10;
            if (exp_v >= 100) begin exp_v = 100; exp_up = 1'b0; end
        end else begin
            exp_v -= 10;
            if (exp_v <= -100) begin exp_v = -100; exp_up = 1'b1; end
        end
    endtask

    task automatic get_locked();
        trans = 500;
        tick(9);
        chk("reach_locked", locked, 1);
    endtask

    task automatic rail_event(input longint rail_val, input longint exp_relock);
        get_locked();
        pid_out = rail_val;
        tick();
        chk("rail_first_state", state, 3);
        chk("rail_first_pid_on", pid_on, 1);
        tick();
        chk("rail_state", state, 1);
        chk("rail_pid_on", pid_on, 0);
        chk("rail_locked", locked, 0);
        chk("rail_relock", relock_cnt, exp_relock);
        pid_out = 0;
        trans   = 100;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; trans = 0; thr_lock = 400; thr_lost = 200;
        sweep_LL = -100; sweep_UL = 100; sweep_step = 10; sweep_div = 0;
        LL = -1000; UL = 1000; pid_out = 0;
        #2;
        chk("rst_state", state, 0);
        chk("rst_sweep", sweep_out, 0);
        chk("rst_pid_on", pid_on, 0);
        chk("rst_locked", locked, 0);
        chk("rst_relock", relock_cnt, 0);
        tick(2);
        rst_n = 1'b1;

        // Triangle sweep across both limits
        en = 1'b1;
        tick();
        chk("sweep_entry_state", state, 1);
        chk("sweep_entry_value", sweep_out, 0);
        for (int i = 0; i < 40; i++) begin
            tick();
            ramp_model();
            chk("ramp", sweep_out, exp_v);
        end

        // Engage, frozen sweep, settle to lock
        trans = 500;
        tick();
        ramp_model();
        chk("engage_state", state, 2);
        chk("engage_pid_on", pid_on, 1);
        chk("engage_sweep", sweep_out, 10);
        tick(7);
        chk("settle_state", state, 2);
        chk("settle_locked", locked, 0);
        chk("settle_sweep", sweep_out, 10);
        tick();
        chk("lock_state", state, 3);
        chk("lock_locked", locked, 1);
        chk("lock_pid_on", pid_on, 1);

        // Short dropout: hold pulse, stays locked
        trans = 100;
        tick();
        chk("hld_on", pid_hld, 1);
        chk("hld_state", state, 3);
        tick(2);
        chk("dropout_state", state, 3);
        trans = 500;
        tick();
        chk("hld_off", pid_hld, 0);
        chk("recover_state", state, 3);
        chk("recover_relock", relock_cnt, 0);

        // Full dropout: relock
        trans = 100;
        tick(3);
        chk("loss3_state", state, 3);
        tick();
        chk("loss_state", state, 1);
        chk("loss_relock", relock_cnt, 1);
        chk("loss_pid_on", pid_on, 0);
        chk("loss_locked", locked, 0);
        chk("loss_hld", pid_hld, 0);

        // Loss and rail trip together count once
        get_locked();
        trans = 100;
        tick(2);
        pid_out = 1000;
        tick();
        chk("both_pre_state", state, 3);
        tick();
        chk("both_state", state, 1);
        chk("both_relock", relock_cnt, 2);
        pid_out = 0;

        // Rail relocks up to saturation
        for (int k = 0; k < 252; k++) rail_event(1000, 3 + k);
        rail_event(1000, 255);
        rail_event(-1000, 255);

        // Disable mid-ENGAGE
        trans = 500;
        tick();
        chk("en_engage_state", state, 2);
        tick(3);
        en = 1'b0;
        tick();
        chk("dis_state", state, 0);
        chk("dis_pid_on", pid_on, 0);
        chk("dis_relock", relock_cnt, 255);
        trans = 0;

        // Degenerate sweep window
        sweep_LL = 50; sweep_UL = 50; en = 1'b1;
        tick(2);
        chk("degen_value", sweep_out, 50);
        tick(3);
        chk("degen_hold", sweep_out, 50);
        chk("degen_state", state, 1);

        // Asynchronous reset while locked
        get_locked();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_sweep", sweep_out, 0);
        chk("arst_pid_on", pid_on, 0);
        chk("arst_hld", pid_hld, 0);
        chk("arst_locked", locked, 0);
        chk("arst_relock", relock_cnt, 0);

        // Restart after reset with a slower prescaler
        #2;
        rst_n = 1'b1;
        sweep_LL = -100; sweep_UL = 100; sweep_div = 2; trans = 0;
        tick();
        chk("restart_state", state, 1);
        tick(2);
        chk("restart_hold", sweep_out, 0);
        tick();
        chk("restart_step", sweep_out, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
